// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment table for the seg_scan display driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] hex2seg(input logic [3:0] i_val);
      logic [6:0] w_seg;
      case (i_val)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         default: w_seg = 7'h0E;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot counter for seg_scan: counts 0..P-1 and flags the last count of each slot.
module seg_prescaler #(
   parameter int unsigned P  = 16,
   parameter int unsigned CW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   output logic [CW-1:0] o_cnt,
   output logic          o_tick
);

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == CW'(P - 1));
   assign o_cnt  = r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)    r_cnt <= '0;
      else if (o_tick) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner with PWM brightness and frame-aligned display update.
// Optional leading-zero suppression is built only when SEG_LZ_EN is defined.
module seg_scan import seg_pkg::*; #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned CLK_HZ   = 100000000,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned PWM_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank,
   input  logic [PWM_BITS-1:0]   bright,
   input  logic                  lz_en,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int unsigned P     = CLK_HZ / SCAN_HZ;
   localparam int unsigned CW    = (P > 1) ? $clog2(P) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]               w_cnt;
   logic                        w_tick;
   logic                        w_frame_end;
   logic [IDX_W-1:0]            r_idx;

   logic [DIGITS-1:0][3:0]      r_sh_dig,   r_act_dig;
   logic [DIGITS-1:0]           r_sh_dp,    r_act_dp;
   logic [DIGITS-1:0]           r_sh_blank, r_act_blank;

   logic [31:0]                 w_on_lim;
   logic                        w_pwm_on;
   logic                        w_lz_sup;
   logic [3:0]                  w_nib;
   logic [DIGITS-1:0]           w_an;
   logic [6:0]                  w_seg;
   logic                        w_dp;

   logic [DIGITS-1:0]           r_an;
   logic [6:0]                  r_seg;
   logic                        r_dp;
   logic                        r_fd;

   seg_prescaler #(.P(P), .CW(CW)) u_presc (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .o_cnt   (w_cnt),
      .o_tick  (w_tick)
   );

   assign w_frame_end = w_tick && (r_idx == IDX_W'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (!reset_n)    r_idx <= '0;
      else if (w_tick) r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
   end

   // Shadow catches every load; active only changes at the frame wrap so a
   // frame is never drawn with a mix of old and new digits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sh_dig    <= '0;
         r_sh_dp     <= '0;
         r_sh_blank  <= '0;
         r_act_dig   <= '0;
         r_act_dp    <= '0;
         r_act_blank <= '0;
      end else begin
         if (load) begin
            r_sh_dig   <= digits;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank;
         end
         if (w_frame_end) begin
            r_act_dig   <= load ? digits : r_sh_dig;
            r_act_dp    <= load ? dp_in  : r_sh_dp;
            r_act_blank <= load ? blank  : r_sh_blank;
         end
      end
   end

   // Product in 64 bits; after the shift the limit is below P, so it fits 32.
   assign w_on_lim = 32'((64'(bright) * 64'(P)) >> PWM_BITS);
   assign w_pwm_on = (w_cnt != '0) && (32'(w_cnt) < w_on_lim);
   assign w_nib    = r_act_dig[r_idx];

`ifdef SEG_LZ_EN
   logic w_zero_run;
   always_comb begin
      w_zero_run = 1'b1;
      w_lz_sup   = 1'b0;
      for (int j = DIGITS - 1; j >= 1; j--) begin
         w_zero_run = w_zero_run && (r_act_dig[j] == 4'd0);
         if (r_idx == IDX_W'(j)) w_lz_sup = lz_en && w_zero_run;
      end
   end
`else
   logic w_unused_lz;
   assign w_unused_lz = lz_en;
   assign w_lz_sup    = 1'b0;
`endif

   // A suppressed leading zero keeps its anode so its decimal point can light.
   always_comb begin
      w_an  = '1;
      w_seg = hex2seg(w_nib);
      w_dp  = ~r_act_dp[r_idx];
      if (r_act_blank[r_idx]) begin
         w_seg = SEG_BLANK;
         w_dp  = 1'b1;
      end else begin
         if (w_lz_sup) w_seg = SEG_BLANK;
         if (w_pwm_on) w_an[r_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_an  <= '1;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
         r_fd  <= 1'b0;
      end else begin
         r_an  <= w_an;
         r_seg <= w_seg;
         r_dp  <= w_dp;
         r_fd  <= w_frame_end;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (DIGITS=4, P=16, PWM_BITS=2): a frame-position
// reference model queues the expected outputs for every clock, a monitor compares.
module tb_seg_scan;

   localparam int P     = 16;
   localparam int ND    = 4;
   localparam int FRAME = P * ND;

   logic        clk;
   logic        reset_n;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic [1:0]  bright;
   logic        lz_en;
   logic        load;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seg_scan #(.DIGITS(4), .CLK_HZ(1600), .SCAN_HZ(100), .PWM_BITS(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .digits     (digits),
      .dp_in      (dp_in),
      .blank      (blank),
      .bright     (bright),
      .lz_en      (lz_en),
      .load       (load),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   typedef struct {
      logic [15:0] dig;
      logic [3:0]  dp;
      logic [3:0]  blank;
   } disp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_pos   = 0;
   int   m_rst_cnt = 0;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Reference model: the scan is just a position within the 64-cycle frame.
   initial begin
      disp_t sh, ac, live;
      exp_t  e;
      int    slot, d, lim;
      logic  sup;
      logic [3:0] nib;
      sh = '{16'h0, 4'h0, 4'h0};
      ac = sh;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            e = '{4'hF, 7'h7F, 1'b1, 1'b0};
            m_pos = 0;
            sh = '{16'h0, 4'h0, 4'h0};
            ac = sh;
            m_rst_cnt++;
         end else begin
            live = '{digits, dp_in, blank};
            slot = m_pos % P;
            d    = m_pos / P;
            lim  = (int'(bright) * P) >> 2;
            nib  = ac.dig[d*4 +: 4];
            sup  = 1'b0;
`ifdef SEG_LZ_EN
            if (lz_en && d > 0) begin
               sup = 1'b1;
               for (int j = d; j < ND; j++) if (ac.dig[j*4 +: 4] != 4'h0) sup = 1'b0;
            end
`endif
            e.an  = 4'hF;
            e.seg = hex_seg(nib);
            e.dp  = ~ac.dp[d];
            e.fd  = (m_pos == FRAME - 1);
            if (ac.blank[d]) begin
               e.seg = 7'h7F;
               e.dp  = 1'b1;
            end else begin
               if (sup) e.seg = 7'h7F;
               if (slot >= 1 && slot < lim) e.an[d] = 1'b0;
            end
            if (m_pos == FRAME - 1) ac = load ? live : sh;
            if (load) sh = live;
            m_pos = (m_pos + 1) % FRAME;
         end
         q.push_back(e);
      end
   end

   // Monitor: pop and compare every cycle; also time frame_done spacing.
   initial begin
      exp_t e;
      int   cyc = 0, prev_fd = 0, rst_seen = 0;
      bit   have_prev = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
               n_fail++;
               $display("FAIL out @%0d: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                        cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
         end
         if (rst_seen != m_rst_cnt) begin
            rst_seen  = m_rst_cnt;
            have_prev = 0;
         end
         if (frame_done === 1'b1) begin
            if (have_prev) begin
               n_tests++;
               if (cyc - prev_fd != FRAME) begin
                  n_fail++;
                  $display("FAIL fd_period @%0d: got %0d, want %0d", cyc, cyc - prev_fd, FRAME);
               end
            end
            prev_fd   = cyc;
            have_prev = 1;
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_pos(input int p);
      for (int k = 0; k < 200 && m_pos != p; k++) @(negedge clk);
      if (m_pos != p) begin
         $display("FAIL wait_pos: got %0d, want %0d", m_pos, p);
         $fatal(1, "scan position never reached");
      end
   endtask

   initial begin
      reset_n = 1'b0; load = 1'b0; digits = 16'h0; dp_in = 4'h0;
      blank = 4'h0; bright = 2'd3; lz_en = 1'b0;
      run(3);
      reset_n = 1'b1;
      run(1);
      digits = 16'h1234;
      pulse_load();
      run(2 * FRAME);
      bright = 2'd2;
      run(FRAME + 5);
      bright = 2'd0;
      run(2 * FRAME + 3);
      bright = 2'd3;
      wait_pos(20);
      digits = 16'hABCD;
      pulse_load();
      run(FRAME + 10);
      wait_pos(FRAME - 1);
      digits = 16'h5678;
      pulse_load();
      run(FRAME + 6);
      digits = 16'h0070; dp_in = 4'b1000; lz_en = 1'b1;
      pulse_load();
      run(2 * FRAME);
      digits = 16'h9E0F; dp_in = 4'b0101; blank = 4'b0010; lz_en = 1'b0;
      pulse_load();
      run(2 * FRAME);
      wait_pos(37);
      reset_n = 1'b0;
      run(1);
      reset_n = 1'b1;
      run(FRAME + 20);
      for (int it = 0; it < 30; it++) begin
         digits = 16'($urandom);
         if ($urandom_range(0, 2) == 0) digits[15:8] = 8'h00;
         dp_in  = 4'($urandom);
         blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         bright = 2'($urandom_range(0, 3));
         lz_en  = 1'($urandom);
         if ($urandom_range(0, 3) == 0) wait_pos(FRAME - 1);
         else run($urandom_range(0, 40));
         pulse_load();
         run($urandom_range(10, 80));
      end
      run(FRAME + 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter CLK_HZ, default 100000000, input clock frequency.
REQ-003 SHALL have parameter SCAN_HZ, default 1000, slot rate (one digit per slot); P = CLK_HZ/SCAN_HZ, P SHALL be >= 2^PWM_BITS.
REQ-004 SHALL have parameter PWM_BITS, default 4, brightness resolution.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port digits  input  4*DIGITS  hex nibble per digit; digit i is [4i+3:4i]; digit 0 is rightmost.
REQ-008 SHALL have port dp_in  input  DIGITS  decimal point per digit, 1 = lit.
REQ-009 SHALL have port blank  input  DIGITS  1 = digit fully dark.
REQ-010 SHALL have port bright  input  PWM_BITS  brightness level; 0 = dark.
REQ-011 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-012 SHALL have port load  input  1  one-cycle strobe that captures digits/dp_in/blank.
REQ-013 SHALL have port an  output  DIGITS  anode enables, active-low.
REQ-014 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-015 SHALL have port dp  output  1  decimal point, active-low.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-017 A slot counter SHALL count 0..P-1 and wrap; at the wrap the digit index SHALL advance 0,1,..,DIGITS-1,0.
REQ-018 frame_done SHALL pulse for one cycle when the index wraps from DIGITS-1 to 0.
REQ-019 load SHALL copy the inputs into a shadow register; the shadow SHALL transfer to the active register only at a frame boundary (the index wrap to 0).
REQ-020 If load and a frame boundary coincide, the active register SHALL take the live inputs directly.
REQ-021 The active anode SHALL be low only when 1 <= slot count < (bright*P) >> PWM_BITS; slot count 0 SHALL always be dead time with all anodes high.
REQ-022 Segment encoding SHALL be the standard hex table 0-F (b = lowercase, d = lowercase).
REQ-023 For a blanked digit, seg SHALL be 7'h7F, dp SHALL be 1 and its anode SHALL stay high.
REQ-024 an, seg, dp and frame_done SHALL be registered, with one-cycle latency from the counter state.
REQ-025 The comparison in REQ-021 SHALL be computed at 32 bits, with no overflow for any legal parameters.

Reset
REQ-026 While reset_n is 0 at a clk edge: an all-ones, seg 7'h7F, dp 1, frame_done 0, counters 0, index 0, shadow and active registers 0.
REQ-027 Reset asserted mid-slot SHALL take effect at the next edge; after release, scanning SHALL restart at digit 0, slot count 0.

Configuration
REQ-028 With SEG_LZ_EN defined, when lz_en=1, digit i (i>0) SHALL be blanked if its value and all more significant values are 0; dp SHALL still follow dp_in, and digit 0 SHALL never be suppressed.
REQ-029 Without SEG_LZ_EN, lz_en SHALL be ignored and no suppression logic SHALL be built.

Structure
REQ-030 Package seg_pkg SHALL hold the hex-to-segment table function and SEG_BLANK = 7'h7F.
REQ-031 Sub-module seg_prescaler SHALL implement the slot counter and wrap tick.

Verification (DIGITS=4, CLK_HZ=1600, SCAN_HZ=100 so P=16, PWM_BITS=2)
REQ-032 Reset, then load digits=16'h1234, bright=3: after the first frame boundary, an cycles 1110,1101,1011,0111; seg for digit 0 = 7'h19 ("4"); anode low for slot counts 1..11 (11 cycles per slot).
REQ-033 bright=2 -> anode low 7 cycles per slot; bright=0 -> an stays all-ones, frame_done still pulses every 64 cycles.
REQ-034 load 16'hABCD mid-frame -> displayed digits unchanged until the next frame_done; load in the same cycle as the boundary -> new value shown in the following frame's slot 0.
REQ-035 SEG_LZ_EN defined, lz_en=1, digits=16'h0070, dp_in=4'b1000 -> digits 3 and 2 dark except digit 3's dp lit; digit 0 shows "0" (7'h40).
REQ-036 blank=4'b0010 -> digit 1 anode never low; reset_n low for one cycle mid-slot -> the next edge shows all-ones an, and scanning restarts at digit 0.
